// File: rtl/fft_pkg.sv
// fft_pkg -- shared types and constants for the FFT datapath blocks.
//   cplx_t : packed complex sample at the default 16-bit component width.
//   CRE/CIM: index of the real/imaginary component inside a complex word.
package fft_pkg;
   localparam int FFT_DW = 16;
   localparam int CRE    = 0;
   localparam int CIM    = 1;

   typedef logic [1:0][FFT_DW-1:0] cplx_t;
endpackage

// File: rtl/cplx_conj_mul.sv
// cplx_conj_mul -- combinational full-width complex multiply p = d * conj(w).
//   d_i : [1:0][DATA_WIDTH:0]  operand (sum/difference width), signed
//   w_i : [1:0][FRAC_BITS:0]   twiddle, Q1.FRAC_BITS, signed
//   p_o : [1:0][PW-1:0]        unshifted result, product width plus one guard bit
module cplx_conj_mul
   import fft_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int FRAC_BITS  = 15,
   localparam int DW1 = DATA_WIDTH + 1,
   localparam int PW  = DW1 + FRAC_BITS + 2
) (
   input  logic [1:0][DW1-1:0]     d_i,
   input  logic [1:0][FRAC_BITS:0] w_i,
   output logic [1:0][PW-1:0]      p_o
);
   logic signed [PW-1:0] rr, ii, ir, ri;

   // Operands are extended to the result width first so each product is
   // computed at full precision regardless of context sizing.
   assign rr = PW'($signed(d_i[CRE])) * PW'($signed(w_i[CRE]));
   assign ii = PW'($signed(d_i[CIM])) * PW'($signed(w_i[CIM]));
   assign ir = PW'($signed(d_i[CIM])) * PW'($signed(w_i[CRE]));
   assign ri = PW'($signed(d_i[CRE])) * PW'($signed(w_i[CIM]));

   assign p_o[CRE] = rr + ii;
   assign p_o[CIM] = ir - ri;
endmodule

// File: rtl/ibutterfly_pipe.sv
// ibutterfly_pipe -- two-stage pipelined DIF inverse radix-2 butterfly.
//   a = x + y ; b = (x - y) * conj(W), optional 1/2 scaling, saturation.
// Ports:
//   clk_i, rst_i (sync, active high)
//   valid_i/ready_o, twid_i, x_i, y_i : input beat
//   valid_o/ready_i, a_o, b_o         : output beat
//   sat_o                             : sticky saturation flag
// Build option: define IBFLY_ROUND_EN for round-half-up at the final shift;
// otherwise every shift truncates (floor).
module ibutterfly_pipe
   import fft_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int FRAC_BITS  = 15,
   parameter int SCALE      = 1
) (
   input  logic                        clk_i,
   input  logic                        rst_i,
   input  logic                        valid_i,
   output logic                        ready_o,
   input  logic [1:0][FRAC_BITS:0]     twid_i,
   input  logic [1:0][DATA_WIDTH-1:0]  x_i,
   input  logic [1:0][DATA_WIDTH-1:0]  y_i,
   output logic                        valid_o,
   input  logic                        ready_i,
   output logic [1:0][DATA_WIDTH-1:0]  a_o,
   output logic [1:0][DATA_WIDTH-1:0]  b_o,
   output logic                        sat_o
);
   localparam int DW1 = DATA_WIDTH + 1;
   localparam int AW  = DATA_WIDTH + 2;      // sum plus room for the rounding add
   localparam int WW  = FRAC_BITS + 1;
   localparam int PW  = DW1 + WW + 1;
   localparam int RW  = PW + 1;              // headroom for the rounding add
   localparam int BSH = FRAC_BITS + ((SCALE == 1) ? 1 : 0);
`ifdef IBFLY_ROUND_EN
   localparam int RND_EN = 1;
`else
   localparam int RND_EN = 0;
`endif
   // With scaling, the product shift and the 1/2 shift collapse into one
   // shift by BSH, so a single half-LSB constant rounds the whole thing.
   localparam logic signed [RW-1:0] BRND = (RND_EN == 1) ? (RW'(1) << (BSH - 1)) : '0;
   localparam logic signed [AW-1:0] ARND = ((RND_EN == 1) && (SCALE == 1)) ? AW'(1) : '0;
   localparam logic signed [RW-1:0] MAXV = RW'((64'(1) << (DATA_WIDTH - 1)) - 64'(1));
   localparam logic signed [RW-1:0] MINV = -MAXV - RW'(1);

   logic                         s1_vld_q, s1_vld_d, s2_vld_q, s2_vld_d;
   logic                         s2_sat_q, s2_sat_d, sat_q, sat_d;
   logic [1:0][AW-1:0]           s1_a_q, s1_a_d;
   logic [1:0][DW1-1:0]          s1_d_q, s1_d_d;
   logic [1:0][WW-1:0]           s1_w_q, s1_w_d;
   logic [1:0][DATA_WIDTH-1:0]   s2_a_q, s2_a_d, s2_b_q, s2_b_d;
   logic [1:0][PW-1:0]           prod;
   logic                         s2_adv, in_fire;
   logic signed [AW-1:0]         sum_t [2];
   logic signed [RW-1:0]         b_t   [2];
   logic [DATA_WIDTH:0]          sa_t  [2];
   logic [DATA_WIDTH:0]          sb_t  [2];

   function automatic logic [DATA_WIDTH:0] sat_fn(input logic signed [RW-1:0] v);
      if (v > MAXV)      return {1'b1, MAXV[DATA_WIDTH-1:0]};
      else if (v < MINV) return {1'b1, MINV[DATA_WIDTH-1:0]};
      else               return {1'b0, v[DATA_WIDTH-1:0]};
   endfunction

   cplx_conj_mul #(.DATA_WIDTH(DATA_WIDTH), .FRAC_BITS(FRAC_BITS)) u_cmul (
      .d_i (s1_d_q),
      .w_i (s1_w_q),
      .p_o (prod)
   );

   always_comb begin
      // S1 moves into S2 exactly when S2 can take a beat.
      s2_adv   = !s2_vld_q || ready_i;
      ready_o  = !s1_vld_q || s2_adv;
      in_fire  = valid_i && ready_o;

      s1_vld_d = ready_o ? valid_i : s1_vld_q;
      s1_a_d   = s1_a_q;
      s1_d_d   = s1_d_q;
      s1_w_d   = s1_w_q;
      s2_vld_d = s2_adv ? s1_vld_q : s2_vld_q;
      s2_a_d   = s2_a_q;
      s2_b_d   = s2_b_q;
      s2_sat_d = s2_sat_q;
      sat_d    = sat_q | (s2_vld_q && ready_i && s2_sat_q);

      for (int c = 0; c < 2; c++) begin
         sum_t[c] = AW'($signed(x_i[c])) + AW'($signed(y_i[c]));
         b_t[c]   = (RW'($signed(prod[c])) + BRND) >>> BSH;
         sa_t[c]  = sat_fn(RW'($signed(s1_a_q[c])));
         sb_t[c]  = sat_fn(b_t[c]);
      end

      if (in_fire) begin
         for (int c = 0; c < 2; c++) begin
            s1_a_d[c] = (SCALE == 1) ? AW'((sum_t[c] + ARND) >>> 1) : sum_t[c];
            s1_d_d[c] = DW1'($signed(x_i[c])) - DW1'($signed(y_i[c]));
         end
         s1_w_d = twid_i;
      end

      if (s2_adv && s1_vld_q) begin
         for (int c = 0; c < 2; c++) begin
            s2_a_d[c] = sa_t[c][DATA_WIDTH-1:0];
            s2_b_d[c] = sb_t[c][DATA_WIDTH-1:0];
         end
         s2_sat_d = sa_t[0][DATA_WIDTH] | sa_t[1][DATA_WIDTH]
                  | sb_t[0][DATA_WIDTH] | sb_t[1][DATA_WIDTH];
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         s1_vld_q <= 1'b0;
         s2_vld_q <= 1'b0;
         s2_sat_q <= 1'b0;
         sat_q    <= 1'b0;
         s1_a_q   <= '0;
         s1_d_q   <= '0;
         s1_w_q   <= '0;
         s2_a_q   <= '0;
         s2_b_q   <= '0;
      end else begin
         s1_vld_q <= s1_vld_d;
         s2_vld_q <= s2_vld_d;
         s2_sat_q <= s2_sat_d;
         sat_q    <= sat_d;
         s1_a_q   <= s1_a_d;
         s1_d_q   <= s1_d_d;
         s1_w_q   <= s1_w_d;
         s2_a_q   <= s2_a_d;
         s2_b_q   <= s2_b_d;
      end
   end

   assign valid_o = s2_vld_q;
   assign a_o     = s2_a_q;
   assign b_o     = s2_b_q;
   assign sat_o   = sat_q;
endmodule

// File: tb/tb_ibutterfly_pipe.sv
// tb_ibutterfly_pipe -- directed-vector bench for ibutterfly_pipe (SCALE=0).
module tb_ibutterfly_pipe;
   import fft_pkg::*;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              valid_i = 1'b0;
   logic              ready_i = 1'b1;
   logic              ready_o, valid_o, sat_o;
   logic [1:0][15:0]  twid = '0;
   cplx_t             x = '0, y = '0, a_o, b_o;
   int                n_chk = 0, n_err = 0;

   always #5 clk = ~clk;

   ibutterfly_pipe #(.DATA_WIDTH(16), .FRAC_BITS(15), .SCALE(0)) dut (
      .clk_i   (clk),
      .rst_i   (rst),
      .valid_i (valid_i),
      .ready_o (ready_o),
      .twid_i  (twid),
      .x_i     (x),
      .y_i     (y),
      .valid_o (valid_o),
      .ready_i (ready_i),
      .a_o     (a_o),
      .b_o     (b_o),
      .sat_o   (sat_o)
   );

   task automatic chk(input string tag, input longint got, input longint exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic set_beat(input int xr, input int xi, input int yr, input int yi,
                           input int wr, input int wi);
      x[CRE] = 16'(xr); x[CIM] = 16'(xi);
      y[CRE] = 16'(yr); y[CIM] = 16'(yi);
      twid[CRE] = 16'(wr); twid[CIM] = 16'(wi);
   endtask

   task automatic check_out(input string tag, input int ar, input int ai,
                            input int br, input int bi);
      chk({tag, "_valid"}, longint'(valid_o), 1);
      chk({tag, "_a_re"}, longint'($signed(a_o[CRE])), ar);
      chk({tag, "_a_im"}, longint'($signed(a_o[CIM])), ai);
      chk({tag, "_b_re"}, longint'($signed(b_o[CRE])), br);
      chk({tag, "_b_im"}, longint'($signed(b_o[CIM])), bi);
   endtask

   initial begin
      int   sent, rcv, exp_b;
      logic saw;
      logic [15:0] held;

      // reset state
      tick; tick;
      rst = 1'b0;
      chk("rst_valid_o", valid_o, 0);
      chk("rst_sat_o", sat_o, 0);
      chk("rst_ready_o", ready_o, 1);
      chk("rst_a_o", a_o, 0);
      chk("rst_b_o", b_o, 0);

      // real scaling by ~1.0: 800*32767/32768 = 799.97
`ifdef IBFLY_ROUND_EN
      exp_b = 800;
`else
      exp_b = 799;
`endif
      set_beat(1000, 0, 200, 0, 32767, 0);
      valid_i = 1'b1;
      tick;
      valid_i = 1'b0;
      chk("t030_lat1_valid", valid_o, 0);
      tick;
      check_out("t030", 1200, 0, exp_b, 0);
      tick;

      // conj(-j) = +j rotates (100,0) to (0,100)
      set_beat(100, 0, 0, 0, 0, -32768);
      valid_i = 1'b1;
      tick;
      valid_i = 1'b0;
      chk("t031_lat1_valid", valid_o, 0);
      tick;
      check_out("t031", 100, 0, 0, 100);
      tick;
      chk("t031_sat_clear", sat_o, 0);

      // a overflows both components
      set_beat(32767, 32767, 32767, 32767, 32767, 0);
      valid_i = 1'b1;
      tick;
      valid_i = 1'b0;
      tick;
      check_out("t032", 32767, 32767, 0, 0);
      tick;
      chk("t032_sat_set", sat_o, 1);
      chk("t032_drained", valid_o, 0);

      // backpressure: four beats, ready_i low for the first three cycles
      sent = 0;
      rcv  = 0;
      held = '0;
      for (int c = 0; c < 30 && rcv < 4; c++) begin
         ready_i = (c >= 3);
         valid_i = (sent < 4);
         set_beat(sent + 1, 0, 0, 0, 0, 0);
         #1;
         if (c == 2) begin
            chk("t033_ready_low", ready_o, 0);
            held = a_o[CRE];
         end
         if (c == 3) chk("t033_hold", a_o[CRE], held);
         if (valid_o && ready_i) begin
            chk("t033_order", longint'($signed(a_o[CRE])), rcv + 1);
            rcv++;
         end
         if (valid_i && ready_o) sent++;
         tick;
      end
      valid_i = 1'b0;
      chk("t033_count", rcv, 4);
      chk("t033_sat_sticky", sat_o, 1);

      // reset with two beats in flight, plus one offered during reset
      ready_i = 1'b0;
      for (int k = 0; k < 2; k++) begin
         set_beat(50 + k, 0, 0, 0, 0, 0);
         valid_i = 1'b1;
         tick;
      end
      rst = 1'b1;
      set_beat(77, 0, 0, 0, 0, 0);
      tick;
      rst = 1'b0;
      valid_i = 1'b0;
      ready_i = 1'b1;
      chk("t034_valid_o", valid_o, 0);
      chk("t034_sat_o", sat_o, 0);
      chk("t034_ready_o", ready_o, 1);
      saw = 1'b0;
      for (int k = 0; k < 5; k++) begin
         if (valid_o) saw = 1'b1;
         tick;
      end
      chk("t034_no_stale", saw, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
